// File: rtl/counter_seq_ctrl.sv
// Sequencing controller for an external loadable up/down counter: runs one-shot,
// periodic or ping-pong sweeps between a start and end value and reports endpoint hits.
module counter_seq_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             clear_ni,
   input  logic             cmd_valid_i,
   output logic             cmd_ready_o,
   input  logic [WIDTH-1:0] cmd_start_i,
   input  logic [WIDTH-1:0] cmd_end_i,
   input  logic [1:0]       cmd_mode_i,
   input  logic             abort_i,
   output logic [WIDTH-1:0] cnt_d_o,
   output logic             cnt_load_o,
   output logic             cnt_up_down_o,
   input  logic [WIDTH-1:0] cnt_qd_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [7:0]       pass_cnt_o
);

   localparam logic [1:0] ModePeriodic = 2'b01;
   localparam logic [1:0] ModePingPong = 2'b10;

   typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] start_q, start_d;
   logic [WIDTH-1:0] end_q, end_d;
   logic [WIDTH-1:0] tgt_q, tgt_d;
   logic [1:0]       mode_q, mode_d;
   logic             dir_q, dir_d;
   logic             done_q, done_d;
   logic [7:0]       pass_cnt_q, pass_cnt_d;
   logic             hit;

   assign hit        = (cnt_qd_i == tgt_q);
   assign done_o     = done_q;
   assign pass_cnt_o = pass_cnt_q;

   always_ff @(posedge clk_i or negedge clear_ni) begin
      if (!clear_ni) begin
         state_q    <= StIdle;
         start_q    <= '0;
         end_q      <= '0;
         tgt_q      <= '0;
         mode_q     <= 2'b00;
         dir_q      <= 1'b1;
         done_q     <= 1'b0;
         pass_cnt_q <= 8'h00;
      end else begin
         state_q    <= state_d;
         start_q    <= start_d;
         end_q      <= end_d;
         tgt_q      <= tgt_d;
         mode_q     <= mode_d;
         dir_q      <= dir_d;
         done_q     <= done_d;
         pass_cnt_q <= pass_cnt_d;
      end
   end

   // The counter has no enable: every non-counting cycle reloads qd to freeze it.
   always_comb begin
      state_d       = state_q;
      start_d       = start_q;
      end_d         = end_q;
      tgt_d         = tgt_q;
      mode_d        = mode_q;
      dir_d         = dir_q;
      done_d        = 1'b0;
      pass_cnt_d    = pass_cnt_q;
      cnt_load_o    = 1'b1;
      cnt_d_o       = cnt_qd_i;
      cnt_up_down_o = 1'b1;
      cmd_ready_o   = 1'b0;
      busy_o        = 1'b1;

      unique case (state_q)
         StIdle: begin
            busy_o      = 1'b0;
            cmd_ready_o = ~abort_i;
            if (cmd_valid_i && !abort_i) begin
               start_d    = cmd_start_i;
               end_d      = cmd_end_i;
               mode_d     = cmd_mode_i;
               dir_d      = (cmd_end_i >= cmd_start_i);
               tgt_d      = cmd_end_i;
               pass_cnt_d = 8'h00;
               state_d    = StLoad;
            end
         end
         StLoad: begin
            if (abort_i) begin
               state_d = StIdle;
            end else begin
               cnt_d_o = start_q;
               state_d = StRun;
            end
         end
         StRun: begin
            cnt_up_down_o = dir_q;
            if (abort_i) begin
               state_d = StIdle;
            end else if (hit) begin
               done_d = 1'b1;
               if (pass_cnt_q != 8'hFF) begin
                  pass_cnt_d = pass_cnt_q + 8'd1;
               end
               // A zero-length ping-pong has nowhere to turn, so it holds like periodic.
               if (mode_q == ModePeriodic || (mode_q == ModePingPong && start_q == end_q)) begin
                  cnt_d_o = start_q;
               end else if (mode_q == ModePingPong) begin
                  cnt_load_o    = 1'b0;
                  cnt_up_down_o = ~dir_q;
                  dir_d         = ~dir_q;
                  tgt_d         = (tgt_q == end_q) ? start_q : end_q;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               cnt_load_o = 1'b0;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Bench for counter_seq_ctrl: models the external counter, drives directed and random
// range commands and checks every cycle against an arithmetic sweep model.
module tb_counter_seq_ctrl;

   logic       clk = 1'b0;
   logic       clear_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [7:0] cmd_start;
   logic [7:0] cmd_end;
   logic [1:0] cmd_mode;
   logic       abort;
   logic [7:0] cnt_d;
   logic       cnt_load;
   logic       cnt_up_down;
   logic [7:0] qd = 8'h00;
   logic       busy;
   logic       done;
   logic [7:0] pass_cnt;

   int total = 0;
   int bad   = 0;

   counter_seq_ctrl #(.WIDTH(8)) dut (
      .clk_i        (clk),
      .clear_ni     (clear_n),
      .cmd_valid_i  (cmd_valid),
      .cmd_ready_o  (cmd_ready),
      .cmd_start_i  (cmd_start),
      .cmd_end_i    (cmd_end),
      .cmd_mode_i   (cmd_mode),
      .abort_i      (abort),
      .cnt_d_o      (cnt_d),
      .cnt_load_o   (cnt_load),
      .cnt_up_down_o(cnt_up_down),
      .cnt_qd_i     (qd),
      .busy_o       (busy),
      .done_o       (done),
      .pass_cnt_o   (pass_cnt)
   );

   always #5 clk = ~clk;

   // The external 8-bit loadable up/down counter.
   always @(posedge clk) begin
      if (cnt_load) qd <= cnt_d;
      else if (cnt_up_down) qd <= qd + 8'd1;
      else qd <= qd - 8'd1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int span(input int s, input int e);
      return (e >= s) ? e - s : s - e;
   endfunction

   // Counter value k cycles into RUN, from the sweep shape alone.
   function automatic logic [7:0] exp_qd(input int s, input int e, input int m, input int k);
      int len;
      int off;
      int p;
      len = span(s, e);
      if (m == 1) begin
         off = k % (len + 1);
      end else if (m == 2) begin
         if (len == 0) off = 0;
         else begin
            p   = k % (2 * len);
            off = (p <= len) ? p : 2 * len - p;
         end
      end else begin
         off = (k < len) ? k : len;
      end
      return (e >= s) ? 8'(s + off) : 8'(s - off);
   endfunction

   function automatic bit exp_hit(input int s, input int e, input int m, input int k);
      int len;
      len = span(s, e);
      if (m == 1) return (k % (len + 1)) == len;
      if (m == 2) return (len == 0) || (k >= len && (k % len) == 0);
      return k == len;
   endfunction

   // Runs one command from IDLE; abort_k < 0 means no abort (one-shot only).
   task automatic run_seq(input int s, input int e, input int m, input int abort_k);
      int  hits;
      int  len;
      int  max_k;
      int  end_k;
      bit  aborted;
      bit  one_shot;
      len      = span(s, e);
      one_shot = (m == 0 || m == 3);
      max_k    = (abort_k >= 0) ? abort_k : len;
      aborted  = 1'b0;
      end_k    = 0;
      hits     = 0;
      cmd_start = 8'(s);
      cmd_end   = 8'(e);
      cmd_mode  = 2'(m);
      cmd_valid = 1'b1;
      #1;
      check("idle_ready", cmd_ready, 1);
      check("idle_busy", busy, 0);
      @(negedge clk);
      check("load_busy", busy, 1);
      check("load_ld", cnt_load, 1);
      check("load_d", cnt_d, s);
      check("load_ready", cmd_ready, 0);
      check("load_pass", pass_cnt, 0);
      for (int k = 0; k <= max_k; k++) begin
         @(negedge clk);
         check("run_qd", qd, exp_qd(s, e, m, k));
         check("run_done", done, (k > 0 && exp_hit(s, e, m, k - 1)) ? 1 : 0);
         check("run_pass", pass_cnt, (hits > 255) ? 255 : hits);
         check("run_busy", busy, 1);
         check("run_ready", cmd_ready, 0);
         end_k = k;
         if (k == abort_k) begin
            abort     = 1'b1;
            cmd_valid = 1'b0;
            aborted   = 1'b1;
            break;
         end
         if (exp_hit(s, e, m, k)) hits++;
         if (one_shot && k == len) begin
            cmd_valid = 1'b0;
            break;
         end
      end
      @(negedge clk);
      if (aborted) begin
         check("abort_busy", busy, 0);
         check("abort_done", done, 0);
         check("abort_qd", qd, exp_qd(s, e, m, end_k));
         check("abort_pass", pass_cnt, (hits > 255) ? 255 : hits);
         check("abort_ready", cmd_ready, 0);
         cmd_valid = 1'b1;
         @(negedge clk);
         check("abort_block", busy, 0);
         check("abort_hold", qd, exp_qd(s, e, m, end_k));
         abort     = 1'b0;
         cmd_valid = 1'b0;
      end else begin
         check("fin_done", done, 1);
         check("fin_busy", busy, 0);
         check("fin_qd", qd, e);
         check("fin_pass", pass_cnt, 1);
         @(negedge clk);
         check("fin_done_low", done, 0);
         check("fin_hold", qd, e);
      end
   endtask

   initial begin
      int s;
      int e;
      int m;
      int a;
      clear_n   = 1'b0;
      cmd_valid = 1'b0;
      cmd_start = 8'h00;
      cmd_end   = 8'h00;
      cmd_mode  = 2'b00;
      abort     = 1'b0;
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_pass", pass_cnt, 0);
      check("rst_ld", cnt_load, 1);
      check("rst_ud", cnt_up_down, 1);
      clear_n = 1'b1;
      @(negedge clk);

      run_seq(8'h02, 8'h05, 0, -1);       // one-shot up
      run_seq(8'h03, 8'h00, 1, 13);       // periodic down
      run_seq(8'h01, 8'h03, 2, 11);       // ping-pong
      run_seq(8'h00, 8'h10, 0, 4);        // abort mid sweep
      run_seq(8'h09, 8'h04, 3, -1);       // mode 11 as one-shot, down
      run_seq(8'h80, 8'h80, 1, 300);      // saturation
      run_seq(8'h40, 8'h40, 2, 5);        // ping-pong on a point
      run_seq(8'h20, 8'h23, 0, 3);        // abort exactly on the hit

      for (int i = 0; i < 10; i++) begin
         s = int'($urandom_range(0, 60));
         e = ($urandom_range(0, 4) == 0) ? s : int'($urandom_range(0, 60));
         m = int'($urandom_range(0, 3));
         if (m == 1 || m == 2) a = int'($urandom_range(0, 3 * span(s, e) + 4));
         else if ($urandom_range(0, 3) == 0) a = int'($urandom_range(0, span(s, e)));
         else a = -1;
         run_seq(s, e, m, a);
      end

      // Reset in the middle of a ping-pong run.
      cmd_start = 8'h10;
      cmd_end   = 8'h11;
      cmd_mode  = 2'b10;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (4) @(negedge clk);
      check("pre_rst_qd", qd, 8'h11);
      check("pre_rst_done", done, 1);
      check("pre_rst_pass", pass_cnt, 2);
      clear_n = 1'b0;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_pass", pass_cnt, 0);
      check("mid_rst_ld", cnt_load, 1);
      @(negedge clk);
      clear_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("post_rst_ld", cnt_load, 1);
         check("post_rst_d", cnt_d, qd);
         check("post_rst_qd", qd, 8'h11);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "time limit");
   end

endmodule
